// File: rtl/eq_pkg.sv
// Shared definitions for the equalizer mixer: Q2.14 gain constants, sample/gain
// typedefs, the mixer FSM states and the output saturation helper.
package eq_pkg;

    localparam int GAIN_FRAC = 14;
    localparam logic [15:0] GAIN_UNITY = 16'h4000;

    localparam int SAMPLE_BITS = 16;
    localparam int GAIN_BITS   = 16;

    typedef logic signed [SAMPLE_BITS-1:0] sample_t;
    typedef logic signed [GAIN_BITS-1:0]   gain_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_OUTPUT = 2'd2
    } state_t;

    // Clamp v into the signed range of a w-bit word.
    function automatic longint sat_clip(input longint v, input int unsigned w);
        longint hi;
        longint lo;
        hi = (64'sd1 <<< (w - 32'd1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 32'd1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/eq_gain_bank.sv
// Per-band gain storage: a shadow bank written at any time and an active bank
// that takes a copy of the shadow on commit, so a running mix never sees a change.
module eq_gain_bank
    import eq_pkg::*;
#(
    parameter int BANDS  = 8,
    parameter int GAIN_W = 16,
    parameter int AW     = $clog2(BANDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [GAIN_W-1:0] wr_data_i,
    input  logic              commit_i,
    input  logic [AW-1:0]     rd_idx_i,
    output logic [GAIN_W-1:0] rd_gain_o
);

    logic [GAIN_W-1:0] shadow_q [BANDS];
    logic [GAIN_W-1:0] active_q [BANDS];

    // Shadow bank: ignores clk_enable; addresses without a matching band are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < BANDS; k++) shadow_q[k] <= GAIN_W'(GAIN_UNITY);
        end else begin
            for (int k = 0; k < BANDS; k++) begin
                if (wr_en_i && (wr_addr_i == AW'(k))) shadow_q[k] <= wr_data_i;
            end
        end
    end

    // Active bank: takes the pre-write shadow contents on a same-edge write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < BANDS; k++) active_q[k] <= GAIN_W'(GAIN_UNITY);
        end else if (commit_i) begin
            active_q <= shadow_q;
        end
    end

    assign rd_gain_o = active_q[rd_idx_i];

endmodule

// File: rtl/eq_band_mixer.sv
// Equalizer band mixer: snapshots BANDS filter outputs, applies per-band Q2.14
// gains with a sequential MAC, then rounds and emits one sample with a valid pulse.
// Define EQ_MIXER_SAT_EN to clip the output (and enable sat_flag); otherwise it wraps.
module eq_band_mixer
    import eq_pkg::*;
#(
    parameter int BANDS  = 8,
    parameter int DATA_W = 16,
    parameter int GAIN_W = 16,
    parameter int ACC_W  = DATA_W + GAIN_W + $clog2(BANDS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clk_enable,
    input  logic                      sample_valid,
    input  logic [BANDS*DATA_W-1:0]   band_in,
    input  logic                      gain_wr_en,
    input  logic [$clog2(BANDS)-1:0]  gain_wr_addr,
    input  logic [GAIN_W-1:0]         gain_wr_data,
    output logic [DATA_W-1:0]         mix_out,
    output logic                      mix_valid,
    output logic                      busy,
    output logic                      sat_flag,
    output logic                      overrun
);

    localparam int IDX_W  = $clog2(BANDS);
    localparam int PROD_W = DATA_W + GAIN_W;
    localparam logic signed [ACC_W-1:0] ROUND_C = ACC_W'(64'sd1 <<< (GAIN_FRAC - 1));

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]         snap_q [BANDS];
    logic [DATA_W-1:0]         snap_d [BANDS];
    logic [DATA_W-1:0]         mix_q, mix_d;
    logic                      valid_q, valid_d;
    logic                      busy_q, busy_d;
    logic                      sat_q, sat_d;
    logic                      ovr_q, ovr_d;

    logic [GAIN_W-1:0]         gain_s;
    logic signed [PROD_W-1:0]  prod_s;
    logic signed [ACC_W-1:0]   round_s;
    logic [DATA_W-1:0]         out_s;
    logic                      clipped_s;
    logic                      commit_s;

    assign commit_s = clk_enable && (state_q == ST_IDLE) && sample_valid;

    eq_gain_bank #(
        .BANDS  (BANDS),
        .GAIN_W (GAIN_W),
        .AW     (IDX_W)
    ) u_gain_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (gain_wr_en),
        .wr_addr_i (gain_wr_addr),
        .wr_data_i (gain_wr_data),
        .commit_i  (commit_s),
        .rd_idx_i  (idx_q),
        .rd_gain_o (gain_s)
    );

    assign prod_s  = $signed(snap_q[idx_q]) * $signed(gain_s);
    assign round_s = (acc_q + ROUND_C) >>> GAIN_FRAC;

`ifdef EQ_MIXER_SAT_EN
    longint rlong_s;
    longint clip_s;

    // Clip the rounded sum to the output word and flag any clipping.
    always_comb begin
        rlong_s   = longint'(round_s);
        clip_s    = sat_clip(rlong_s, DATA_W);
        out_s     = clip_s[DATA_W-1:0];
        clipped_s = (clip_s != rlong_s);
    end
`else
    assign out_s     = DATA_W'(round_s);
    assign clipped_s = 1'b0;
`endif

    // Next-state and datapath control for IDLE -> ACCUM -> OUTPUT.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        snap_d  = snap_q;
        mix_d   = mix_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        sat_d   = sat_q;
        ovr_d   = ovr_q;
        case (state_q)
            ST_IDLE: begin
                if (sample_valid) begin
                    for (int k = 0; k < BANDS; k++) snap_d[k] = band_in[k*DATA_W +: DATA_W];
                    acc_d   = '0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_ACCUM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                acc_d = acc_q + ACC_W'(prod_s);
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(BANDS - 1)) begin
                    state_d = ST_OUTPUT;
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_OUTPUT: begin
                mix_d   = out_s;
                valid_d = 1'b1;
                sat_d   = sat_q | clipped_s;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
        // A strobe arriving while a mix is still running is lost.
        if (sample_valid && busy_q) begin
            ovr_d = 1'b1;
        end else begin
            ovr_d = ovr_q;
        end
    end

    // State and output registers, frozen while clk_enable is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            for (int k = 0; k < BANDS; k++) snap_q[k] <= '0;
            mix_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            sat_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else if (clk_enable) begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            snap_q  <= snap_d;
            mix_q   <= mix_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            sat_q   <= sat_d;
            ovr_q   <= ovr_d;
        end
    end

    assign mix_out   = mix_q;
    assign mix_valid = valid_q;
    assign busy      = busy_q;
    assign sat_flag  = sat_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_eq_band_mixer.sv
// Self-checking bench for eq_band_mixer: directed vector table, multi-cycle
// corner sequences and a randomized phase against a sample-level reference model.
module tb_eq_band_mixer;

    localparam int BANDS = 8;
    localparam int LAT   = BANDS + 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clk_enable;
    logic         sample_valid;
    logic [127:0] band_in;
    logic         gain_wr_en;
    logic [2:0]   gain_wr_addr;
    logic [15:0]  gain_wr_data;
    logic [15:0]  mix_out;
    logic         mix_valid;
    logic         busy;
    logic         sat_flag;
    logic         overrun;

    int n_checks = 0;
    int n_err    = 0;

    eq_band_mixer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clk_enable   (clk_enable),
        .sample_valid (sample_valid),
        .band_in      (band_in),
        .gain_wr_en   (gain_wr_en),
        .gain_wr_addr (gain_wr_addr),
        .gain_wr_data (gain_wr_data),
        .mix_out      (mix_out),
        .mix_valid    (mix_valid),
        .busy         (busy),
        .sat_flag     (sat_flag),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // Reference model: whole-sample arithmetic plus an enabled-edge countdown.
    logic signed [15:0] m_gain [BANDS];
    int          m_pend;
    logic        m_valid, m_busy, m_ovr, m_sat, m_next_sat;
    logic [15:0] m_out, m_next_out;

    function automatic void model_reset();
        for (int k = 0; k < BANDS; k++) m_gain[k] = 16'sh4000;
        m_pend = 0; m_valid = 1'b0; m_busy = 1'b0; m_ovr = 1'b0; m_sat = 1'b0;
        m_out = 16'h0000; m_next_out = 16'h0000; m_next_sat = 1'b0;
    endfunction

    function automatic void model_result();
        longint sum;
        longint r;
        sum = 64'sd0;
        for (int k = 0; k < BANDS; k++)
            sum += longint'($signed(band_in[k*16 +: 16])) * longint'(m_gain[k]);
        r = (sum + 64'sd8192) >>> 14;
`ifdef EQ_MIXER_SAT_EN
        if (r > 64'sd32767) begin
            m_next_out = 16'h7FFF; m_next_sat = 1'b1;
        end else if (r < -64'sd32768) begin
            m_next_out = 16'h8000; m_next_sat = 1'b1;
        end else begin
            m_next_out = r[15:0]; m_next_sat = 1'b0;
        end
`else
        m_next_out = r[15:0];
        m_next_sat = 1'b0;
`endif
    endfunction

    function automatic void model_edge();
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (clk_enable) begin
            m_valid = 1'b0;
            if (m_pend > 0) begin
                if (sample_valid) m_ovr = 1'b1;
                m_pend--;
                if (m_pend == 0) begin
                    m_valid = 1'b1;
                    m_out   = m_next_out;
                    m_sat   = m_sat | m_next_sat;
                end
            end else if (sample_valid) begin
                model_result();
                m_pend = LAT;
            end
            m_busy = (m_pend > 0);
        end
        if (gain_wr_en) m_gain[gain_wr_addr] = gain_wr_data;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("mix_valid", longint'(mix_valid), longint'(m_valid));
        chk("busy",      longint'(busy),      longint'(m_busy));
        chk("overrun",   longint'(overrun),   longint'(m_ovr));
        chk("sat_flag",  longint'(sat_flag),  longint'(m_sat));
        chk("mix_out",   longint'(mix_out),   longint'(m_out));
    endtask

    task automatic set_gains(input logic [15:0] g);
        for (int k = 0; k < BANDS; k++) begin
            gain_wr_en = 1'b1; gain_wr_addr = 3'(k); gain_wr_data = g;
            tick();
        end
        gain_wr_en = 1'b0;
    endtask

    // One sample from acceptance to mix_valid, with optional stall, gain write and extra strobe.
    task automatic run_sample(input logic [127:0] bands, input int hold, input bit do_wr,
                              input bit extra, output int lat, output logic [15:0] out);
        band_in = bands; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        lat = -1; out = 16'h0000;
        for (int c = 1; c <= 60; c++) begin
            clk_enable   = !(c >= 3 && c < 3 + hold);
            sample_valid = extra && (c == 3);
            gain_wr_en   = do_wr && (c == 4);
            gain_wr_addr = 3'd0; gain_wr_data = 16'h0000;
            tick();
            if (mix_valid) begin
                lat = c; out = mix_out;
                break;
            end
        end
        clk_enable = 1'b1; sample_valid = 1'b0; gain_wr_en = 1'b0;
    endtask

    typedef struct {
        logic [127:0] bands;
        logic [15:0]  gain;
        logic [15:0]  exp_out;
        logic         exp_sat;
    } vec_t;

    initial begin
        vec_t        vecs [5];
        int          lat;
        int          nval;
        logic [15:0] out;

        vecs[0] = '{bands: {112'd0, 16'd1000}, gain: 16'h4000, exp_out: 16'd1000, exp_sat: 1'b0};
        vecs[1] = '{bands: {8{16'd100}},       gain: 16'h2000, exp_out: 16'd400,  exp_sat: 1'b0};
        vecs[2] = '{bands: {112'd0, 16'd3},    gain: 16'h2000, exp_out: 16'd2,    exp_sat: 1'b0};
        vecs[3] = '{bands: {112'd0, 16'hFFFD}, gain: 16'h2000, exp_out: 16'hFFFF, exp_sat: 1'b0};
`ifdef EQ_MIXER_SAT_EN
        vecs[4] = '{bands: {8{16'h7FFF}},      gain: 16'h4000, exp_out: 16'h7FFF, exp_sat: 1'b1};
`else
        vecs[4] = '{bands: {8{16'h7FFF}},      gain: 16'h4000, exp_out: 16'hFFF8, exp_sat: 1'b0};
`endif

        rst_n = 1'b0; clk_enable = 1'b1; sample_valid = 1'b0; band_in = '0;
        gain_wr_en = 1'b0; gain_wr_addr = 3'd0; gain_wr_data = 16'h0000;
        model_reset();
        #1;
        chk("reset mix_out",   longint'(mix_out),   64'sd0);
        chk("reset mix_valid", longint'(mix_valid), 64'sd0);
        chk("reset busy",      longint'(busy),      64'sd0);
        chk("reset sat_flag",  longint'(sat_flag),  64'sd0);
        chk("reset overrun",   longint'(overrun),   64'sd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Directed table: uniform gains per vector.
        for (int i = 0; i < 5; i++) begin
            set_gains(vecs[i].gain);
            tick();
            run_sample(vecs[i].bands, 0, 1'b0, 1'b0, lat, out);
            chk($sformatf("vec%0d mix_out", i), longint'(out), longint'(vecs[i].exp_out));
            chk($sformatf("vec%0d latency", i), longint'(lat), longint'(LAT));
            chk($sformatf("vec%0d sat_flag", i), longint'(sat_flag), longint'(vecs[i].exp_sat));
            tick();
        end

        // Strobe dropped during accumulation: one result, overrun set.
        set_gains(16'h4000);
        run_sample({112'd0, 16'd1000}, 0, 1'b0, 1'b1, lat, out);
        chk("overrun mix_out", longint'(out), 64'sd1000);
        chk("overrun latency", longint'(lat), longint'(LAT));
        nval = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (mix_valid) nval++;
        end
        chk("overrun extra valids", longint'(nval), 64'sd0);
        chk("overrun flag", longint'(overrun), 64'sd1);

        // clk_enable low for 5 cycles mid-ACCUM stretches latency only.
        run_sample({112'd0, 16'd1000}, 5, 1'b0, 1'b0, lat, out);
        chk("stall mix_out", longint'(out), 64'sd1000);
        chk("stall latency", longint'(lat), longint'(LAT + 5));
        tick();

        // Gain write during ACCUM only reaches the next sample.
        run_sample({112'd0, 16'd1000}, 0, 1'b1, 1'b0, lat, out);
        chk("gainwr current", longint'(out), 64'sd1000);
        tick();
        run_sample({112'd0, 16'd1000}, 0, 1'b0, 1'b0, lat, out);
        chk("gainwr next", longint'(out), 64'sd0);
        tick();

        // Reset mid-ACCUM aborts the sample with no valid pulse.
        band_in = {8{16'd500}}; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        tick(); tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("abort busy",      longint'(busy),      64'sd0);
        chk("abort mix_valid", longint'(mix_valid), 64'sd0);
        chk("abort mix_out",   longint'(mix_out),   64'sd0);
        chk("abort overrun",   longint'(overrun),   64'sd0);
        chk("abort sat_flag",  longint'(sat_flag),  64'sd0);
        tick(); tick();
        rst_n = 1'b1;
        nval = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (mix_valid) nval++;
        end
        chk("abort no valid", longint'(nval), 64'sd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            clk_enable   = ($urandom_range(0, 9) != 0);
            sample_valid = ($urandom_range(0, 4) == 0);
            band_in      = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 1) == 0) band_in = band_in >> $urandom_range(0, 120);
            gain_wr_en   = ($urandom_range(0, 7) == 0);
            gain_wr_addr = 3'($urandom_range(0, 7));
            gain_wr_data = 16'($urandom_range(0, 65535));
            tick();
        end
        clk_enable = 1'b1; sample_valid = 1'b0; gain_wr_en = 1'b0;
        for (int c = 0; c < 12; c++) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/eq_band_mixer.md
# eq_band_mixer

Downstream stage of the per-band `filter` instances in the 8-band equalizer. It snapshots the BANDS filter outputs on each sample strobe and scales each band by a programmable gain with a sequential multiply-accumulate. It rounds and saturates the sum to one 16-bit equalized sample, then presents it with a one-cycle valid pulse. It shares the filters' `clk` and `clk_enable` domain.

## Interface
Parameters:
- BANDS, 8, number of band filter outputs mixed
- DATA_W, 16, signed sample width (in and out)
- GAIN_W, 16, signed gain width, Q2.14 format (0x4000 = 1.0)
- ACC_W, DATA_W+GAIN_W+$clog2(BANDS), accumulator width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- clk_enable  in  1  global clock enable, shared with the filters
- sample_valid  in  1  all band_in words hold a new sample
- band_in  in  BANDS*DATA_W  packed signed filter outputs; band k is bits [k*DATA_W +: DATA_W]
- gain_wr_en  in  1  gain shadow write strobe
- gain_wr_addr  in  $clog2(BANDS)  band index to write
- gain_wr_data  in  GAIN_W  signed Q2.14 gain
- mix_out  out  DATA_W  signed mixed sample
- mix_valid  out  1  one enabled-cycle pulse, mix_out is new
- busy  out  1  accumulation in progress
- sat_flag  out  1  sticky: an output was clipped
- overrun  out  1  sticky: a sample_valid was dropped

## Operation
- Reset values: state IDLE, mix_out 0, mix_valid 0, busy 0, sat_flag 0, overrun 0, accumulator 0, index 0. All shadow and active gains reset to 0x4000.
- Every register except the gain shadow updates only on edges where clk_enable=1.
- Gain shadow: gain_wr_en writes gain_shadow[gain_wr_addr] on any edge, independent of clk_enable. An address ≥ BANDS is ignored.
- FSM IDLE → ACCUM → OUTPUT → IDLE.
- IDLE: when sample_valid=1, latch band_in into the snapshot and copy gain_shadow into gain_active. Then set acc=0, idx=0, busy=1, and go to ACCUM.
- ACCUM: each enabled cycle, acc += snap[idx]*gain_active[idx], with a full-precision signed product. idx++. When idx=BANDS-1, go to OUTPUT.
- OUTPUT: r = (acc + 2^13) >>> 14, which is round-half-up. Clip r to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Register the result into mix_out and assert mix_valid. Set sat_flag if clipping occurred. Clear busy and return to IDLE.
- mix_valid stays high until the next enabled edge, where it clears. mix_out holds until the next result.
- sample_valid while busy=1 is dropped: overrun is set and the running mix is unaffected.
- Gain writes during ACCUM affect only the next sample. A write on the same edge as sample acceptance is not included in that sample.
- sat_flag and overrun clear only on reset.
- rst_n asserted mid-ACCUM aborts immediately to the reset values. No mix_valid is produced for the aborted sample.

## Timing
- With sample_valid accepted at enabled edge E0, mix_valid is high after edge E0+BANDS+1. For BANDS=8 this is 9 enabled edges.
- Minimum sample spacing: BANDS+2 enabled cycles. The strobe on the edge where mix_valid asserts (state IDLE) is accepted.
- clk_enable=0 freezes the FSM, idx, acc and outputs in place.

## Configuration
- EQ_MIXER_SAT_EN defined: clip as described; sat_flag is functional.
- EQ_MIXER_SAT_EN undefined: mix_out = r[DATA_W-1:0], a two's-complement wrap; sat_flag is tied to 0.

## Structure
- Shared package `eq_pkg`:
  - Q2.14 constants: GAIN_FRAC=14, GAIN_UNITY=16'h4000.
  - Sample and gain typedefs.
  - FSM state enum.
  - Saturation helper function.
- One sub-module, `eq_gain_bank`: shadow/active gain register pair with write port, commit strobe and indexed read.

## Test plan
- All gains unity, band0=1000, others 0 → mix_out=1000, mix_valid 9 enabled edges after sample_valid.
- All gains 0x2000, all bands 100 → mix_out=400, sat_flag=0.
- All gains unity, all bands 0x7FFF → mix_out=32767, sat_flag=1. Without EQ_MIXER_SAT_EN: mix_out=0xFFF8 and sat_flag=0.
- Rounding with gains 0x2000: band0=3 → mix_out=2; band0=-3 → mix_out=-1.
- sample_valid at cycle 0 and cycle 3 → exactly one mix_valid, overrun=1. Toggle clk_enable low for 5 cycles mid-ACCUM → result unchanged, latency extended by 5.
- Write gain0=0 during ACCUM → current result uses unity, next sample uses 0. Assert rst_n mid-ACCUM → no mix_valid, all outputs at reset values.
